// File: rtl/return_prediction_checker.sv
// return_prediction_checker
//
// Tracks return-address predictions made at fetch and checks each one against
// the actual target reported by execute, oldest first.
//
// Parameters:
//   ADDR_WIDTH  - width of return addresses
//   QUEUE_DEPTH - outstanding predictions held (power of two, >= 2)
//
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   pred_valid_i/ready_o, pred_addr_i, pred_hit_i
//                       - prediction record; hit = stack non-empty at predict time
//   resolve_valid_i, resolve_target_i
//                       - actual target of the oldest outstanding return
//   flush_i             - pipeline flush, overrides everything else
//   correct_o, mispredict_o, orphan_o
//                       - registered one-cycle result pulses (mutually exclusive)
//   redirect_addr_o     - target to refetch from; updated only on a mispredict
//   count_o, empty_o, full_o
//                       - queue occupancy
//
// Optional feature (macro RPC_STATS_EN):
//   stat_correct_o, stat_mispredict_o - saturating 32-bit result counters,
//   cleared by reset only.

module return_prediction_checker #(
    parameter int ADDR_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           pred_valid_i,
    output logic                           pred_ready_o,
    input  logic [ADDR_WIDTH-1:0]          pred_addr_i,
    input  logic                           pred_hit_i,

    input  logic                           resolve_valid_i,
    input  logic [ADDR_WIDTH-1:0]          resolve_target_i,

    input  logic                           flush_i,

    output logic                           correct_o,
    output logic                           mispredict_o,
    output logic [ADDR_WIDTH-1:0]          redirect_addr_o,
    output logic                           orphan_o,

    output logic [$clog2(QUEUE_DEPTH):0]   count_o,
    output logic                           empty_o,
    output logic                           full_o
`ifdef RPC_STATS_EN
    ,
    output logic [31:0]                    stat_correct_o,
    output logic [31:0]                    stat_mispredict_o
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Queue storage is intentionally left unreset; pointers and count define validity.
    logic [ADDR_WIDTH-1:0] addr_mem [QUEUE_DEPTH];
    logic                  hit_mem  [QUEUE_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic correct_d, mispredict_d, orphan_d;
    logic write_en;
    logic enq;
    logic pop;
    logic head_ok;

    // Occupancy flags and ready come only from registered state.
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(QUEUE_DEPTH));
    assign count_o      = count_q;
    assign pred_ready_o = !full_o && (state_q == RUN);

    assign enq     = pred_valid_i && pred_ready_o;
    assign head_ok = hit_mem[rd_ptr_q] && (addr_mem[rd_ptr_q] == resolve_target_i);

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        correct_d    = 1'b0;
        mispredict_d = 1'b0;
        orphan_d     = 1'b0;
        write_en     = 1'b0;
        pop          = 1'b0;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
        end else if (state_q == RECOVER) begin
            // Resolves are ignored here and ready is low, so nothing enqueues.
            state_d = RUN;
        end else if (resolve_valid_i && empty_o) begin
            orphan_d = 1'b1;
            if (enq) begin
                write_en = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end else if (resolve_valid_i && !head_ok) begin
            // Everything behind the mispredicted return is wrong-path, including
            // a same-cycle enqueue: collapse the queue by snapping rd onto wr.
            mispredict_d = 1'b1;
            state_d      = RECOVER;
            rd_ptr_d     = wr_ptr_q;
            count_d      = '0;
        end else begin
            pop       = resolve_valid_i;
            correct_d = resolve_valid_i;
            if (enq) begin
                write_en = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= RUN;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            correct_o       <= 1'b0;
            mispredict_o    <= 1'b0;
            orphan_o        <= 1'b0;
            redirect_addr_o <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            correct_o    <= correct_d;
            mispredict_o <= mispredict_d;
            orphan_o     <= orphan_d;
            if (mispredict_d) begin
                redirect_addr_o <= resolve_target_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en) begin
            addr_mem[wr_ptr_q] <= pred_addr_i;
            hit_mem[wr_ptr_q]  <= pred_hit_i;
        end
    end

`ifdef RPC_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_correct_o    <= '0;
            stat_mispredict_o <= '0;
        end else begin
            if (correct_d && (stat_correct_o != '1)) begin
                stat_correct_o <= stat_correct_o + 1'b1;
            end
            if (mispredict_d && (stat_mispredict_o != '1)) begin
                stat_mispredict_o <= stat_mispredict_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_return_prediction_checker.sv
module tb_return_prediction_checker;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid;
    logic          pred_ready;
    logic [AW-1:0] pred_addr;
    logic          pred_hit;
    logic          resolve_valid;
    logic [AW-1:0] resolve_target;
    logic          flush;
    logic          correct;
    logic          mispredict;
    logic [AW-1:0] redirect_addr;
    logic          orphan;
    logic [2:0]    count;
    logic          empty;
    logic          full;
`ifdef RPC_STATS_EN
    logic [31:0]   stat_correct;
    logic [31:0]   stat_mispredict;
`endif

    always #5 clk = ~clk;

    return_prediction_checker #(
        .ADDR_WIDTH (AW),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pred_valid_i    (pred_valid),
        .pred_ready_o    (pred_ready),
        .pred_addr_i     (pred_addr),
        .pred_hit_i      (pred_hit),
        .resolve_valid_i (resolve_valid),
        .resolve_target_i(resolve_target),
        .flush_i         (flush),
        .correct_o       (correct),
        .mispredict_o    (mispredict),
        .redirect_addr_o (redirect_addr),
        .orphan_o        (orphan),
        .count_o         (count),
        .empty_o         (empty),
        .full_o          (full)
`ifdef RPC_STATS_EN
        ,
        .stat_correct_o   (stat_correct),
        .stat_mispredict_o(stat_mispredict)
`endif
    );

    // Reference model: a queue of outstanding predictions plus a flag for the
    // single post-mispredict cycle, and the expected registered outputs.
    typedef struct {
        logic [AW-1:0] addr;
        logic          hit;
    } entry_t;

    entry_t        mq[$];
    bit            m_recover;
    bit            m_correct, m_mispredict, m_orphan;
    logic [AW-1:0] m_redirect;
    int unsigned   m_stat_c, m_stat_m;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (mq.size() < DEPTH) && !m_recover;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_recover    = 0;
        m_correct    = 0;
        m_mispredict = 0;
        m_orphan     = 0;
        m_redirect   = '0;
        m_stat_c     = 0;
        m_stat_m     = 0;
    endtask

    task automatic check_all();
        check("count",      count,         mq.size());
        check("empty",      empty,         mq.size() == 0);
        check("full",       full,          mq.size() == DEPTH);
        check("ready",      pred_ready,    model_ready());
        check("correct",    correct,       m_correct);
        check("mispredict", mispredict,    m_mispredict);
        check("orphan",     orphan,        m_orphan);
        check("redirect",   redirect_addr, m_redirect);
        check("onehot",     32'(correct) + 32'(mispredict) + 32'(orphan) <= 1, 1);
`ifdef RPC_STATS_EN
        check("stat_c",     stat_correct,    m_stat_c);
        check("stat_m",     stat_mispredict, m_stat_m);
`endif
    endtask

    // One clock: drive inputs, check ready before the edge, advance the model
    // at the edge, then compare every output just after it.
    task automatic step(input bit pv, input logic [AW-1:0] pa, input bit ph,
                        input bit rv, input logic [AW-1:0] rt, input bit fl);
        bit     rdy;
        entry_t e;
        pred_valid     = pv;
        pred_addr      = pa;
        pred_hit       = ph;
        resolve_valid  = rv;
        resolve_target = rt;
        flush          = fl;
        rdy = model_ready();
        #1 check("ready_pre", pred_ready, rdy);
        @(posedge clk);
        m_correct    = 0;
        m_mispredict = 0;
        m_orphan     = 0;
        if (fl) begin
            mq.delete();
            m_recover = 0;
        end else if (m_recover) begin
            m_recover = 0;
        end else if (rv && mq.size() == 0) begin
            m_orphan = 1;
            if (pv && rdy) mq.push_back('{pa, ph});
        end else if (rv) begin
            e = mq.pop_front();
            if (e.hit && e.addr == rt) begin
                m_correct = 1;
                m_stat_c++;
                if (pv && rdy) mq.push_back('{pa, ph});
            end else begin
                m_mispredict = 1;
                m_stat_m++;
                m_redirect   = rt;
                mq.delete();
                m_recover    = 1;
            end
        end else if (pv && rdy) begin
            mq.push_back('{pa, ph});
        end
        #1 check_all();
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, 0);
    endtask

    task automatic enq(input logic [AW-1:0] a, input bit h);
        step(1, a, h, 0, '0, 0);
    endtask

    task automatic resolve(input logic [AW-1:0] t);
        step(0, '0, 0, 1, t, 0);
    endtask

    // Asynchronous reset applied between clock edges, checked before any edge.
    task automatic mid_reset();
        pred_valid    = 0;
        resolve_valid = 0;
        flush         = 0;
        #2 rst_n = 0;
        model_reset();
        #1 check_all();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 check_all();
    endtask

    initial begin
        logic [AW-1:0] tgt;
        rst_n          = 0;
        pred_valid     = 0;
        pred_addr      = '0;
        pred_hit       = 0;
        resolve_valid  = 0;
        resolve_target = '0;
        flush          = 0;
        model_reset();
        #3 check_all();
        check("rst_ready", pred_ready, 1);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 check_all();

        // Correct prediction, pulse for one cycle.
        enq(32'h100, 1);
        check("r030_count1", count, 1);
        resolve(32'h100);
        check("r030_correct", correct, 1);
        check("r030_count0", count, 0);
        idle();
        check("r030_pulse_end", correct, 0);

        // Mispredict flushes wrong-path entries; resolve during recovery ignored.
        enq(32'h100, 1);
        enq(32'h200, 1);
        enq(32'h300, 1);
        resolve(32'h104);
        check("r031_mispredict", mispredict, 1);
        check("r031_redirect", redirect_addr, 32'h104);
        check("r031_count", count, 0);
        check("r031_ready", pred_ready, 0);
        step(1, 32'h500, 1, 1, 32'h200, 0);
        check("r031_no_correct", correct, 0);
        check("r031_no_orphan", orphan, 0);
        check("r031_ready_back", pred_ready, 1);
        check("r031_redirect_hold", redirect_addr, 32'h104);

        // Address match but stack was empty at prediction time.
        enq(32'h40, 0);
        resolve(32'h40);
        check("r032_mispredict", mispredict, 1);
        check("r032_redirect", redirect_addr, 32'h40);
        idle();

        // Full queue: ready low even with a same-cycle resolve.
        for (int i = 0; i < DEPTH; i++) enq(32'h1000 + 32'(i) * 16, 1);
        check("r033_full", full, 1);
        check("r033_ready", pred_ready, 0);
        step(1, 32'h9000, 1, 1, 32'h1000, 0);
        check("r033_count", count, 3);
        check("r033_correct", correct, 1);
        // Simultaneous enqueue and resolve on a partly filled queue.
        step(1, 32'h2000, 1, 1, 32'h1010, 0);
        check("r021_count", count, 3);
        step(0, '0, 0, 0, '0, 1);

        // Orphan resolve.
        resolve(32'h77);
        check("r034_orphan", orphan, 1);
        check("r034_count", count, 0);

        // Flush beats a same-cycle resolve.
        enq(32'h100, 1);
        enq(32'h200, 1);
        step(0, '0, 0, 1, 32'h100, 1);
        check("r035_count", count, 0);
        check("r035_no_correct", correct, 0);
        enq(32'h300, 1);
        enq(32'h400, 1);
        mid_reset();
        check("r035_rst_count", count, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) tgt = mq[0].addr;
            else tgt = 32'($urandom_range(0, 15)) << 4;
            step($urandom_range(0, 9) < 6,
                 32'($urandom_range(0, 15)) << 4,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 4,
                 tgt,
                 $urandom_range(0, 49) == 0);
            if (i % 750 == 749) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/return_prediction_checker.md
RETURN_PREDICTION_CHECKER -- requirements
Module: return_prediction_checker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of return addresses.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, a power of two and at least 2: number of outstanding return predictions held.
REQ-003 SHALL have ports clk_i (in, 1, sole clock) and rst_ni (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports pred_valid_i (in, 1), pred_ready_o (out, 1), pred_addr_i (in, ADDR_WIDTH) and pred_hit_i (in, 1): fetch-side record of a return prediction and whether the stack was non-empty at prediction time.
REQ-005 SHALL have ports resolve_valid_i (in, 1) and resolve_target_i (in, ADDR_WIDTH): execute-side actual target of the oldest outstanding return.
REQ-006 SHALL have port flush_i (in, 1): external pipeline flush.
REQ-007 SHALL have ports correct_o (out, 1), mispredict_o (out, 1), redirect_addr_o (out, ADDR_WIDTH) and orphan_o (out, 1): registered resolution results.
REQ-008 SHALL have ports count_o (out, $clog2(QUEUE_DEPTH)+1), empty_o (out, 1) and full_o (out, 1): queue occupancy.

Function
REQ-009 SHALL hold predictions in a FIFO of QUEUE_DEPTH entries, each storing {addr, hit}, using wrapping read and write pointers.
REQ-010 SHALL enqueue on a cycle with pred_valid_i && pred_ready_o.
REQ-011 SHALL drive pred_ready_o = !full_o && (state == RUN).
REQ-012 SHALL, when resolve_valid_i is high and the queue is non-empty, dequeue the oldest entry and compare it with resolve_target_i.
REQ-013 SHALL treat the comparison as correct when hit == 1 and addr == resolve_target_i; otherwise as a mispredict.
REQ-014 SHALL, on a correct resolve, pulse correct_o for exactly 1 cycle, starting on the cycle after resolve.
REQ-015 SHALL, on a mispredict, pulse mispredict_o for 1 cycle, starting on the cycle after resolve, with redirect_addr_o = resolve_target_i.
REQ-016 SHALL, on a mispredict, discard all remaining entries and any entry enqueued in the same cycle, because these are wrong-path predictions.
REQ-017 SHALL have an FSM with states RUN and RECOVER.
REQ-018 SHALL transition RUN->RECOVER on a mispredict; RECOVER lasts exactly 1 cycle and then returns to RUN.
REQ-019 SHALL, in RECOVER, hold pred_ready_o = 0 and ignore resolve_valid_i.
REQ-020 SHALL, on resolve_valid_i with an empty queue in RUN, pulse orphan_o for 1 cycle and change no other state.
REQ-021 SHALL support enqueue and resolve in the same cycle with the queue neither full nor empty, leaving count unchanged.
REQ-022 SHALL, when full, deassert pred_ready_o even if a resolve occurs in the same cycle; ready depends only on registered state.
REQ-023 SHALL give flush_i highest priority: empty the queue, go to RUN, and produce no result pulse for a same-cycle resolve.
REQ-024 SHALL hold redirect_addr_o at its last value when mispredict_o is low.
REQ-025 SHALL assert at most one of correct_o, mispredict_o and orphan_o in any cycle.

Reset
REQ-026 SHALL, while rst_ni is low, asynchronously clear the pointers, count_o, correct_o, mispredict_o, orphan_o and redirect_addr_o to 0, set empty_o = 1 and full_o = 0, and enter state RUN.
REQ-027 SHALL, when reset is asserted mid-operation, discard all queued entries; the queue storage itself need not be reset.

Configuration
REQ-028 SHALL, when macro RPC_STATS_EN is defined, add outputs stat_correct_o (out, 32) and stat_mispredict_o (out, 32): saturating counts of correct and mispredict resolves, reset to 0 and not cleared by flush_i.
REQ-029 SHALL, without RPC_STATS_EN, have neither these ports nor the counters; all other behaviour is identical.

Verification
REQ-030 Enqueue 0x100 (hit = 1), then resolve with 0x100 -> correct_o pulses 1 cycle later; count_o goes 1 then 0.
REQ-031 Enqueue 0x100, 0x200 and 0x300, then resolve with 0x104 -> mispredict_o = 1 and redirect_addr_o = 0x104; count_o = 0 and pred_ready_o = 0 for 1 cycle; a correct resolve afterwards produces no pulse.
REQ-032 Enqueue 0x40 with hit = 0, then resolve with 0x40 -> mispredict_o = 1 and redirect_addr_o = 0x40.
REQ-033 Fill the queue to 4 entries -> full_o = 1 and pred_ready_o = 0; a same-cycle resolve and enqueue accepts no enqueue and leaves count_o = 3.
REQ-034 Resolve with an empty queue -> orphan_o pulses 1 cycle; count_o stays 0.
REQ-035 Enqueue 2 entries, then raise flush_i and resolve_valid_i together -> count_o = 0 and no result pulse; asserting rst_ni low mid-queue -> all outputs return to their reset values immediately.
